// File: rtl/puf_pkg.sv
// puf_pkg: shared definitions for the arbiter-PUF challenge/response sequencer.
//   W           - challenge/response width
//   CONST       - fixed word transmitted when the check input selects it
//   state_t     - sequencer states
//   gray_encode - binary to reflected-Gray conversion applied to challenges
package puf_pkg;

  localparam int W = 16;
  localparam logic [W-1:0] CONST = 16'hABCD;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRE   = 3'd1,
    RELAX  = 3'd2,
    LAUNCH = 3'd3,
    TXWAIT = 3'd4
  } state_t;

  function automatic logic [W-1:0] gray_encode(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/puf_vote_acc.sv
// puf_vote_acc: per-bit vote counters for repeated PUF evaluations.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero every lane counter (start of a new challenge)
//   en       : add the current resp bits into their lane counters
//   resp     : PUF response sample
//   voted    : majority word, bit i = (count[i] > NVOTE/2)
// Lanes are 4 bits wide; NVOTE is limited to 15 so a lane never wraps.
module puf_vote_acc #(
  parameter int W     = 16,
  parameter int NVOTE = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] resp,
  output logic [W-1:0] voted
);

  localparam logic [3:0] HALF = 4'(NVOTE / 2);

  logic [3:0] vote [W];

  for (genvar i = 0; i < W; i++) begin : g_lane
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vote[i] <= 4'd0;
      end else if (clr) begin
        vote[i] <= 4'd0;
      end else if (en && resp[i]) begin
        vote[i] <= vote[i] + 4'd1;
      end
    end

    assign voted[i] = (vote[i] > HALF);
  end

endmodule

// File: rtl/puf_crp_ctrl.sv
// puf_crp_ctrl: sequencer between UART receiver, arbiter PUF and UART transmitter.
// A received challenge is Gray-coded onto the PUF, the PUF is fired NVOTE
// times with SETTLE-cycle high and low trigger phases, responses are
// majority-voted per bit, and the result (or CONST when check=1) is handed to
// the transmitter with a completion timeout.
//   clk, rst        : clock, asynchronous active-high reset
//   rx_valid/rx_data: one-cycle challenge strobe and binary challenge
//   check           : sampled at launch, 1 sends CONST instead of the response
//   puf_trig        : PUF launch, rising edge starts a race
//   challenge       : Gray-coded challenge driven to the PUF
//   puf_resp        : PUF response, sampled on the last high trigger cycle
//   tx_en_n/tx_data : active-low transmit request and word
//   tx_done         : one-cycle completion strobe from the transmitter
//   busy            : high whenever the sequencer is not idle
//   overrun/timeout : sticky error flags, cleared only by rst
// Handshake: rx_valid is a strobe that is only consumed in IDLE (otherwise
// dropped and flagged); tx_en_n is held low with tx_data stable until tx_done
// strobes or the timeout expires. Every output is a register, so no input
// reaches an output combinationally.
module puf_crp_ctrl #(
  parameter int             W          = puf_pkg::W,
  parameter int             SETTLE     = 8,
  parameter int             NVOTE      = 3,
  parameter int             TX_TIMEOUT = 4096,
  parameter logic [W-1:0]   CONST      = puf_pkg::CONST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [W-1:0] rx_data,
  input  logic         check,
  output logic         puf_trig,
  output logic [W-1:0] challenge,
  input  logic [W-1:0] puf_resp,
  output logic         tx_en_n,
  output logic [W-1:0] tx_data,
  input  logic         tx_done,
  output logic         busy,
  output logic         overrun,
  output logic         timeout
);

  import puf_pkg::*;

  localparam int PW = $clog2(SETTLE);
  localparam int TW = $clog2(TX_TIMEOUT);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TX_TIMEOUT - 1);
  localparam logic [3:0]    NV         = 4'(NVOTE);

  // Current state is kept as a named signal so checkers can bind to it.
  state_t        state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [3:0]    eval_cnt, eval_nxt;
  logic [TW-1:0] to_cnt, to_nxt;

  logic          puf_trig_nxt, tx_en_n_nxt, busy_nxt, overrun_nxt, timeout_nxt;
  logic [W-1:0]  challenge_nxt, tx_data_nxt;
  logic          vote_clr, vote_en;
  logic [W-1:0]  voted;

  puf_vote_acc #(.W(W), .NVOTE(NVOTE)) u_vote (
    .clk   (clk),
    .rst   (rst),
    .clr   (vote_clr),
    .en    (vote_en),
    .resp  (puf_resp),
    .voted (voted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      eval_cnt  <= '0;
      to_cnt    <= '0;
      puf_trig  <= 1'b0;
      challenge <= '0;
      tx_en_n   <= 1'b1;
      tx_data   <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      eval_cnt  <= eval_nxt;
      to_cnt    <= to_nxt;
      puf_trig  <= puf_trig_nxt;
      challenge <= challenge_nxt;
      tx_en_n   <= tx_en_n_nxt;
      tx_data   <= tx_data_nxt;
      busy      <= busy_nxt;
      overrun   <= overrun_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Next-state logic computes the register inputs, so outputs change on the
  // same edge that enters a state (e.g. puf_trig is high in the first FIRE
  // cycle, tx_en_n is low in the LAUNCH cycle itself).
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    eval_nxt      = eval_cnt;
    to_nxt        = to_cnt;
    puf_trig_nxt  = puf_trig;
    challenge_nxt = challenge;
    tx_en_n_nxt   = tx_en_n;
    tx_data_nxt   = tx_data;
    timeout_nxt   = timeout;
    overrun_nxt   = overrun | (rx_valid && (state != IDLE));
    vote_clr      = 1'b0;
    vote_en       = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          challenge_nxt = gray_encode(rx_data);
          vote_clr      = 1'b1;
          eval_nxt      = '0;
          phase_nxt     = '0;
          puf_trig_nxt  = 1'b1;
          state_nxt     = FIRE;
        end
      end

      FIRE: begin
        if (phase == PHASE_LAST) begin
          vote_en      = 1'b1;
          eval_nxt     = eval_cnt + 4'd1;
          phase_nxt    = '0;
          puf_trig_nxt = 1'b0;
          state_nxt    = RELAX;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end

      RELAX: begin
        if (phase == PHASE_LAST) begin
          phase_nxt = '0;
          if (eval_cnt < NV) begin
            puf_trig_nxt = 1'b1;
            state_nxt    = FIRE;
          end else begin
            // Launch word is registered here so it is valid in the LAUNCH cycle.
            tx_data_nxt = check ? CONST : voted;
            tx_en_n_nxt = 1'b0;
            to_nxt      = '0;
            state_nxt   = LAUNCH;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end

      LAUNCH, TXWAIT: begin
        if (tx_done) begin
          tx_en_n_nxt = 1'b1;
          state_nxt   = IDLE;
        end else if (to_cnt == TO_LAST) begin
          timeout_nxt = 1'b1;
          tx_en_n_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          to_nxt    = to_cnt + 1'b1;
          state_nxt = TXWAIT;
        end
      end

      default: begin
        puf_trig_nxt = 1'b0;
        tx_en_n_nxt  = 1'b1;
        state_nxt    = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_puf_crp_ctrl.sv
// tb_puf_crp_ctrl: directed bench for puf_crp_ctrl with a tx_data scoreboard.
module tb_puf_crp_ctrl;

  localparam int W          = 16;
  localparam int SETTLE     = 8;
  localparam int NVOTE      = 3;
  localparam int TX_TIMEOUT = 4096;
  localparam int PERIOD     = 2 * SETTLE;
  localparam int LAUNCH_CYC = 1 + 2 * NVOTE * SETTLE;

  logic         clk, rst;
  logic         rx_valid, check, tx_done;
  logic [W-1:0] rx_data, puf_resp;
  logic         puf_trig, tx_en_n, busy, overrun, timeout;
  logic [W-1:0] challenge, tx_data;

  puf_crp_ctrl #(
    .W(W), .SETTLE(SETTLE), .NVOTE(NVOTE), .TX_TIMEOUT(TX_TIMEOUT), .CONST(16'hABCD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .check     (check),
    .puf_trig  (puf_trig),
    .challenge (challenge),
    .puf_resp  (puf_resp),
    .tx_en_n   (tx_en_n),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .busy      (busy),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int           n_vec    = 0;
  int           n_err    = 0;
  int           n_push   = 0;
  int           n_launch = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_word;
  logic         prev_en_n = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each falling edge of tx_en_n is one transfer; compare its word.
  always @(negedge clk) begin
    if (rst) begin
      prev_en_n = 1'b1;
    end else begin
      if (prev_en_n && !tx_en_n) begin
        n_launch++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL tx_data: unexpected transfer with word %0h", tx_data);
        end else begin
          exp_word = exp_q.pop_front();
          chk("tx_data", {16'h0, tx_data}, {16'h0, exp_word});
        end
      end
      prev_en_n = tx_en_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle that should carry rx_valid (cycle 0). Returns in the
  // cycle after tx_done, or in the LAUNCH cycle when done_delay < 0.
  task automatic do_txn(input logic [W-1:0] rx, input logic chk_sel,
                        input logic [W-1:0] r0, input logic [W-1:0] r1,
                        input logic [W-1:0] r2, input logic [W-1:0] exp_chal,
                        input logic [W-1:0] exp_tx, input int done_delay,
                        input int ovr_cycle);
    int   trig_bad = 0;
    int   en_bad   = 0;
    int   pulses   = 0;
    logic prev_trig = 1'b0;
    exp_q.push_back(exp_tx);
    n_push++;
    rx_valid = 1'b1;
    rx_data  = rx;
    check    = chk_sel;
    puf_resp = r0;
    step;
    rx_valid = 1'b0;
    rx_data  = ~rx;
    chk("challenge", {16'h0, challenge}, {16'h0, exp_chal});
    chk("busy_start", {31'h0, busy}, 32'd1);
    for (int c = 1; c < LAUNCH_CYC; c++) begin
      if (c == 1 + PERIOD)     puf_resp = r1;
      if (c == 1 + 2 * PERIOD) puf_resp = r2;
      if (c == ovr_cycle) begin
        rx_valid = 1'b1;
        rx_data  = 16'h1234;
      end else begin
        rx_valid = 1'b0;
      end
      if (puf_trig !== (((c - 1) % PERIOD) < SETTLE)) trig_bad++;
      if (puf_trig && !prev_trig) pulses++;
      prev_trig = puf_trig;
      if (tx_en_n !== 1'b1) en_bad++;
      step;
    end
    rx_valid = 1'b0;
    chk("trig_pattern_bad_cycles", trig_bad, 0);
    chk("trig_pulses", pulses, NVOTE);
    chk("tx_en_n_early_cycles", en_bad, 0);
    chk("launch_tx_en_n", {31'h0, tx_en_n}, 32'd0);
    chk("trig_after_votes", {31'h0, puf_trig}, 32'd0);
    chk("challenge_hold", {16'h0, challenge}, {16'h0, exp_chal});
    if (done_delay >= 0) begin
      repeat (done_delay) step;
      tx_done = 1'b1;
      step;
      tx_done = 1'b0;
      chk("release_tx_en_n", {31'h0, tx_en_n}, 32'd1);
      chk("release_busy", {31'h0, busy}, 32'd0);
    end
  endtask

  task automatic chk_reset_values;
    chk("rst_puf_trig", {31'h0, puf_trig}, 32'd0);
    chk("rst_challenge", {16'h0, challenge}, 32'd0);
    chk("rst_tx_en_n", {31'h0, tx_en_n}, 32'd1);
    chk("rst_tx_data", {16'h0, tx_data}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_overrun", {31'h0, overrun}, 32'd0);
    chk("rst_timeout", {31'h0, timeout}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    check    = 1'b0;
    puf_resp = '0;
    tx_done  = 1'b0;
    repeat (3) step;
    chk_reset_values();
    rst = 1'b0;
    step;

    // Constant response, done 10 cycles after launch.
    do_txn(16'h00FF, 1'b0, 16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h0080, 16'h5A5A, 10, 0);
    chk("overrun_clear", {31'h0, overrun}, 32'd0);
    step;

    // Bitwise majority of three different samples.
    do_txn(16'h1234, 1'b0, 16'h00FF, 16'h0F0F, 16'hFFFF, 16'h1B2E, 16'h0FFF, 2, 0);
    step;

    // check=1 sends CONST; second challenge issued the cycle after tx_done.
    do_txn(16'h8000, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'hC000, 16'hABCD, 1, 0);
    do_txn(16'hFFFF, 1'b1, 16'h0000, 16'hFFFF, 16'h0F0F, 16'h8000, 16'hABCD, 1, 0);
    chk("overrun_after_b2b", {31'h0, overrun}, 32'd0);
    step;

    // rx_valid during FIRE is dropped and flagged.
    do_txn(16'h0F0F, 1'b0, 16'hA5A5, 16'h0000, 16'hA5A5, 16'h0888, 16'hA5A5, 5, 4);
    chk("overrun_set", {31'h0, overrun}, 32'd1);
    step;

    // tx_done withheld: timeout after TX_TIMEOUT cycles of tx_en_n low.
    do_txn(16'h0001, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF, -1, 0);
    repeat (TX_TIMEOUT - 1) step;
    chk("timeout_last_cycle_tx_en_n", {31'h0, tx_en_n}, 32'd0);
    chk("timeout_not_yet", {31'h0, timeout}, 32'd0);
    step;
    chk("timeout_tx_en_n", {31'h0, tx_en_n}, 32'd1);
    chk("timeout_set", {31'h0, timeout}, 32'd1);
    chk("timeout_busy", {31'h0, busy}, 32'd0);
    do_txn(16'h0002, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0003, 16'hFFFF, 3, 0);
    chk("timeout_sticky", {31'h0, timeout}, 32'd1);
    step;

    // Reset during RELAX of the second evaluation.
    rx_valid = 1'b1;
    rx_data  = 16'hC3C3;
    puf_resp = 16'hFFFF;
    step;
    rx_valid = 1'b0;
    repeat (27) step;
    chk("pre_rst_busy", {31'h0, busy}, 32'd1);
    chk("pre_rst_challenge", {16'h0, challenge}, 32'h0000A222);
    rst = 1'b1;
    #1;
    chk_reset_values();
    step;
    step;
    rst = 1'b0;
    step;
    do_txn(16'h0003, 1'b0, 16'h1234, 16'h1234, 16'h1234, 16'h0002, 16'h1234, 4, 0);

    repeat (4) step;
    chk("queue_empty", exp_q.size(), 0);
    chk("transfer_count", n_launch, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/puf_crp_ctrl.md
# puf_crp_ctrl

Sequencer for the 16-bit arbiter-PUF challenge/response path, placed between the UART receiver, the PUF core and the UART transmitter. It latches a received binary challenge and Gray-codes it onto the PUF. It fires the PUF a programmable number of times and majority-votes the responses bit by bit. It then hands the voted response, or a fixed test constant, to the transmitter and supervises completion with a timeout.

## Interface
Parameters:
- W, 16, challenge/response width
- SETTLE, 8, cycles per trigger phase (high and low); must be ≥2
- NVOTE, 3, evaluations per challenge; odd, 1..15
- TX_TIMEOUT, 4096, cycles allowed for tx_done after launch
- CONST, 16'hABCD, word sent when check=1

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle pulse: rx_data holds a new challenge
- rx_data  in  W  binary challenge from the UART receiver
- check  in  1  sampled at launch; 1 selects CONST instead of the response
- puf_trig  out  1  PUF launch signal; a rising edge starts a race
- challenge  out  W  Gray-coded challenge to the PUF
- puf_resp  in  W  PUF response, stable by the last high cycle of puf_trig
- tx_en_n  out  1  active-low transmit request to the UART transmitter
- tx_data  out  W  word to transmit
- tx_done  in  1  one-cycle pulse from the transmitter: word sent
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky: rx_valid arrived while busy
- timeout  out  1  sticky: tx_done was not seen within TX_TIMEOUT

## Operation
- Reset values: puf_trig=0, challenge=0, tx_en_n=1, tx_data=0, busy=0, overrun=0, timeout=0, state=IDLE, all counters 0.
- IDLE: on rx_valid, register challenge = rx_data ^ (rx_data >> 1), clear the vote counters and eval_cnt, then go to FIRE.
- FIRE: puf_trig=1 for SETTLE cycles. On the last cycle, each bit i with puf_resp[i]=1 increments vote[i]. eval_cnt then increments and the state goes to RELAX.
- RELAX: puf_trig=0 for SETTLE cycles. At the end, go to FIRE if eval_cnt<NVOTE, otherwise go to LAUNCH.
- LAUNCH (1 cycle): tx_data = check ? CONST : voted word, where bit i = (vote[i] > NVOTE/2). Set tx_en_n=0 and clear the timeout counter.
- TXWAIT: hold tx_en_n=0 and tx_data stable.
  - tx_done: return to IDLE with tx_en_n=1.
  - Counter reaching TX_TIMEOUT-1 with no tx_done: set timeout, deassert tx_en_n, return to IDLE.
- rx_valid in any state other than IDLE is dropped and sets overrun. The challenge is not modified.
- rx_valid and tx_done in the same cycle in TXWAIT: complete the transfer, set overrun, and do not start a new challenge.
- Vote counters are 4 bits per lane and cannot overflow, since NVOTE≤15.
- The sticky flags clear only on rst.
- rst asserted mid-operation forces the reset values immediately, including puf_trig=0.

## Timing
- rx_valid seen in cycle 0 → challenge valid and puf_trig=1 from cycle 1.
- Evaluation k (0-based) has puf_trig high during cycles 1+2k·SETTLE .. SETTLE+2k·SETTLE. puf_resp is sampled in the last of those cycles.
- LAUNCH falls in cycle 1+2·NVOTE·SETTLE. tx_en_n goes low in that cycle, and tx_data is valid in the same cycle.
- Default parameters: tx_en_n falls 49 cycles after rx_valid.
- tx_done in cycle t → tx_en_n=1 and busy=0 in cycle t+1. A new rx_valid is accepted from cycle t+1.
- No combinational path from any input to any output.

## Structure
- Shared package puf_pkg holds W, CONST, the state enum (IDLE, FIRE, RELAX, LAUNCH, TXWAIT) and the gray_encode function.
- One sub-module, puf_vote_acc, implements the per-bit vote counters with clear, sample-enable and majority output. It is parameterised by W and NVOTE.
- Phase/settle counter width is clog2(SETTLE). Timeout counter width is clog2(TX_TIMEOUT).

## Test plan
- rx_data=16'h00FF, check=0, constant puf_resp=16'h5A5A, tx_done 10 cycles after launch:
  - challenge=16'h0080.
  - Exactly 3 puf_trig pulses of 8 cycles each.
  - tx_en_n falls at cycle 49 with tx_data=16'h5A5A.
  - busy drops the cycle after tx_done.
- Successive puf_resp samples 16'h00FF, 16'h0F0F, 16'hFFFF → tx_data=16'h0FFF.
- check=1, any response → tx_data=16'hABCD. Two challenges back to back each produce one transfer.
- rx_valid pulsed during FIRE → overrun=1, challenge unchanged, exactly one transfer.
- tx_done withheld → timeout=1 after TX_TIMEOUT cycles, tx_en_n returns to 1, and the next rx_valid is accepted normally.
- rst asserted during RELAX of the second evaluation → all outputs at their reset values immediately. A fresh rx_valid=16'h0003 then yields challenge=16'h0002 and a full 3-vote sequence.
